// File: rtl/mem_bus_responder_pkg.sv
// Shared types and widths for the CPU data-memory responder.
package mem_bus_responder_pkg;

  localparam int ADDR_LEN      = 32;
  localparam int DATA_LEN      = 32;
  localparam int MEM_WSTRB_LEN = 4;
  localparam int MEM_CNT_LEN   = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_bus_responder.sv
// Word-wide load/store target with programmable wait states between accept and response.
// RAM is written/read on the edge that enters RESP; errors take the same path with no side effects.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_LEN-1:0]      req_addr,
  input  logic [DATA_LEN-1:0]      req_wdata,
  input  logic [MEM_WSTRB_LEN-1:0] req_wstrb,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_LEN-1:0]      resp_rdata,
  output logic                     resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_LEN-3:0] DEPTH_LIM = (ADDR_LEN-2)'(DEPTH_WORDS);
  localparam logic [MEM_CNT_LEN-1:0] CNT_INIT = MEM_CNT_LEN'(LATENCY - 1);

  mem_state_e state_q, state_d;
  logic [MEM_CNT_LEN-1:0]   cnt_q, cnt_d;
  logic                     we_q;
  logic [ADDR_LEN-1:0]      addr_q;
  logic [DATA_LEN-1:0]      wdata_q;
  logic [MEM_WSTRB_LEN-1:0] wstrb_q;
  logic [DATA_LEN-1:0]      rdata_q, rdata_d;
  logic                     err_q;

  logic [DATA_LEN-1:0] mem [DEPTH_WORDS];

  logic                     accept;
  logic                     commit;
  logic                     op_we;
  logic [ADDR_LEN-1:0]      op_addr;
  logic [DATA_LEN-1:0]      op_wdata;
  logic [MEM_WSTRB_LEN-1:0] op_wstrb;
  logic                     op_err;
  logic [IDX_W-1:0]         op_idx;

  assign accept = (state_q == MEM_IDLE) && req_valid;

  // With LATENCY==1 the commit edge is the accept edge, so operands come straight from the request.
  assign op_we    = (state_q == MEM_IDLE) ? req_we    : we_q;
  assign op_addr  = (state_q == MEM_IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == MEM_IDLE) ? req_wdata : wdata_q;
  assign op_wstrb = (state_q == MEM_IDLE) ? req_wstrb : wstrb_q;

  assign op_err = (op_addr[1:0] != 2'b00) || (op_addr[ADDR_LEN-1:2] >= DEPTH_LIM);
  assign op_idx = op_addr[2 +: IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = MEM_RESP;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == MEM_CNT_LEN'(1)) begin
          state_d = MEM_RESP;
        end else begin
          cnt_d = cnt_q - MEM_CNT_LEN'(1);
        end
      end
      MEM_RESP: begin
        if (resp_ready) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign commit  = (state_d == MEM_RESP) && (state_q != MEM_RESP);
  assign rdata_d = (!op_we && !op_err) ? mem[op_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= op_err;
      end
    end
  end

  // RAM has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int b = 0; b < MEM_WSTRB_LEN; b++) begin
        if (op_wstrb[b]) begin
          mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == MEM_IDLE);
  assign resp_valid = (state_q == MEM_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
